// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher sequencer: state encoding, default word
// width and a small helper used by the bit counter.
package xor_cipher_pkg;

    localparam int DATA_SIZE_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LOAD_KEY  = 3'd2,
        ST_LOAD_DATA = 3'd3,
        ST_COMBINE   = 3'd4,
        ST_SHIFT     = 3'd5,
        ST_DONE      = 3'd6
    } cipherState_e;

    // States that last DATA_SIZE cycles and are timed by the bit counter.
    function automatic logic isCounted(input cipherState_e state);
        return (state == ST_LOAD_KEY) || (state == ST_LOAD_DATA) || (state == ST_SHIFT);
    endfunction

endpackage

// File: rtl/xor_cipher_ctrl_if.sv
// Bus between the cipher sequencer and its key/plaintext deserializers:
// parallel words in, clear/enable/loading strobes out.
interface xor_cipher_ctrl_if
    import xor_cipher_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
);

    logic [DATA_SIZE-1:0] iKey;
    logic [DATA_SIZE-1:0] iData;
    logic                 oDes_rst_n;
    logic                 oKey_en;
    logic                 oData_en;
    logic                 oLoading;

    modport master (
        input  iKey,
        input  iData,
        output oDes_rst_n,
        output oKey_en,
        output oData_en,
        output oLoading
    );

    modport slave (
        output iKey,
        output iData,
        input  oDes_rst_n,
        input  oKey_en,
        input  oData_en,
        input  oLoading
    );

endinterface

// File: rtl/xor_cipher_ctrl_piso_shifter.sv
// Parallel-in serial-out shifter: loads a word, shifts left filling with zero,
// presents the MSB. Synchronous clear wins over load and shift.
module piso_shifter
    import xor_cipher_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iClear,
    input  logic                 iLoad,
    input  logic                 iShift,
    input  logic [DATA_SIZE-1:0] iParallel,
    output logic                 oMsb
);

    logic [DATA_SIZE-1:0] shiftReg;
    logic [DATA_SIZE-1:0] shiftNext;
    logic [DATA_SIZE-1:0] shiftedWord;

    assign shiftedWord[0] = 1'b0;
    for (genvar gi = 1; gi < DATA_SIZE; gi++) begin : gShiftBit
        assign shiftedWord[gi] = shiftReg[gi-1];
    end

    always_comb begin
        shiftNext = shiftReg;
        if (iClear) begin
            shiftNext = '0;
        end else if (iLoad) begin
            shiftNext = iParallel;
        end else if (iShift) begin
            shiftNext = shiftedWord;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            shiftReg <= '0;
        end else begin
            shiftReg <= shiftNext;
        end
    end

    assign oMsb = shiftReg[DATA_SIZE-1];

endmodule

// File: rtl/xor_cipher_ctrl.sv
// XOR cipher sequencer: clears and loads the key and plaintext deserializers,
// XORs their words and streams the ciphertext out MSB first.
module xor_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic                 iAbort,
    xor_cipher_ctrl_if.master    desBus,
    output logic                 oSerial_out,
    output logic                 oValid,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oState
);

    localparam int               CNT_W    = $clog2(DATA_SIZE) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cipherState_e     stateReg;
    cipherState_e     stateNext;
    logic [CNT_W-1:0] cntReg;
    logic [CNT_W-1:0] cntNext;
    logic             desRstNReg;
    logic             shiftClear;
    logic             shiftLoad;
    logic             shiftEn;
    logic             shiftMsb;
    logic             cntZero;

    assign cntZero = (cntReg == '0);

    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg;
        shiftClear = 1'b0;

        if (isCounted(stateReg) && !cntZero) begin
            cntNext = cntReg - CNT_ONE;
        end

        if ((stateReg != ST_IDLE) && iAbort) begin
            stateNext  = ST_IDLE;
            cntNext    = '0;
            shiftClear = 1'b1;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (iStart) begin
                        stateNext = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    stateNext = ST_LOAD_KEY;
                    cntNext   = CNT_LOAD;
                end
                ST_LOAD_KEY: begin
                    if (cntZero) begin
                        stateNext = ST_LOAD_DATA;
                        cntNext   = CNT_LOAD;
                    end
                end
                ST_LOAD_DATA: begin
                    if (cntZero) begin
                        stateNext = ST_COMBINE;
                    end
                end
                ST_COMBINE: begin
                    stateNext = ST_SHIFT;
                    cntNext   = CNT_LOAD;
                end
                ST_SHIFT: begin
                    if (cntZero) begin
                        stateNext = ST_DONE;
                    end
                end
                ST_DONE: begin
                    stateNext = ST_IDLE;
                end
                default: begin
                    // Unused encoding 7 falls back to a clean IDLE.
                    stateNext  = ST_IDLE;
                    cntNext    = '0;
                    shiftClear = 1'b1;
                end
            endcase
        end
    end

    // The clear strobe is a flop so the deserializers never see a glitch on it.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stateReg   <= ST_IDLE;
            cntReg     <= '0;
            desRstNReg <= 1'b1;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            desRstNReg <= (stateNext != ST_CLEAR);
        end
    end

    assign shiftLoad = (stateReg == ST_COMBINE);
    assign shiftEn   = (stateReg == ST_SHIFT);

    piso_shifter #(
        .DATA_SIZE (DATA_SIZE)
    ) uPisoShifter (
        .iClk      (iClk),
        .iRst      (iRst),
        .iClear    (shiftClear),
        .iLoad     (shiftLoad),
        .iShift    (shiftEn),
        .iParallel (desBus.iKey ^ desBus.iData),
        .oMsb      (shiftMsb)
    );

    assign desBus.oDes_rst_n = desRstNReg;
    assign desBus.oKey_en    = (stateReg == ST_LOAD_KEY);
    assign desBus.oData_en   = (stateReg == ST_LOAD_DATA);
    assign desBus.oLoading   = (stateReg == ST_LOAD_KEY) || (stateReg == ST_LOAD_DATA);

    assign oValid      = shiftEn;
    assign oSerial_out = shiftEn & shiftMsb;
    assign oBusy       = (stateReg != ST_IDLE);
    assign oDone       = (stateReg == ST_DONE);
    assign oState      = stateReg;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Bench for xor_cipher_ctrl: lane 0 runs DATA_SIZE=8, lane 1 runs DATA_SIZE=32,
// each with behavioural deserializers and a timeline model checked every cycle.
module tb_xor_cipher_ctrl;

    logic        clk;
    logic [1:0]  rstN;
    logic [1:0]  start;
    logic [1:0]  abort;
    logic [1:0]  serial;
    logic [1:0]  valid;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  desRstNObs;
    logic [2:0]  stateObs [2];
    logic [31:0] keyWord  [2];
    logic [31:0] dataWord [2];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int lane, input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL lane%0d %s at %0t: got %h expected %h", lane, name, $time, got, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : gLane
        localparam int N = (gi == 0) ? 8 : 32;

        xor_cipher_ctrl_if #(.DATA_SIZE(N)) desBus ();

        logic [2:0] dutState;

        xor_cipher_ctrl #(.DATA_SIZE(N)) dut (
            .iClk        (clk),
            .iRst        (rstN[gi]),
            .iStart      (start[gi]),
            .iAbort      (abort[gi]),
            .desBus      (desBus),
            .oSerial_out (serial[gi]),
            .oValid      (valid[gi]),
            .oBusy       (busy[gi]),
            .oDone       (done[gi]),
            .oState      (dutState)
        );

        assign stateObs[gi]   = dutState;
        assign desRstNObs[gi] = desBus.oDes_rst_n;

        // Behavioural deserializers: shift in the word MSB first, saturate at N bits.
        logic [N-1:0] keySr, dataSr;
        int           keyCnt, dataCnt;
        always @(posedge clk) begin
            if (!desBus.oDes_rst_n) begin
                keySr <= '0; dataSr <= '0; keyCnt <= 0; dataCnt <= 0;
            end else begin
                if (desBus.oKey_en && desBus.oLoading && keyCnt < N) begin
                    keySr  <= {keySr[N-2:0], keyWord[gi][N-1-keyCnt]};
                    keyCnt <= keyCnt + 1;
                end
                if (desBus.oData_en && desBus.oLoading && dataCnt < N) begin
                    dataSr  <= {dataSr[N-2:0], dataWord[gi][N-1-dataCnt]};
                    dataCnt <= dataCnt + 1;
                end
            end
        end
        assign desBus.iKey  = keySr;
        assign desBus.iData = dataSr;

        // Model: k = cycles since the job was accepted (0 = idle).
        int           k;
        logic [N-1:0] cipher;
        always @(posedge clk or negedge rstN[gi]) begin
            if (!rstN[gi]) begin
                k <= 0;
            end else if (k == 0) begin
                if (start[gi]) begin
                    k      <= 1;
                    cipher <= keyWord[gi][N-1:0] ^ dataWord[gi][N-1:0];
                end
            end else if (abort[gi] || k == 3*N+3) begin
                k <= 0;
            end else begin
                k <= k + 1;
            end
        end

        function automatic logic [2:0] phaseOf(input int kk);
            if (kk == 0)       return 3'd0;
            if (kk == 1)       return 3'd1;
            if (kk <= N+1)     return 3'd2;
            if (kk <= 2*N+1)   return 3'd3;
            if (kk == 2*N+2)   return 3'd4;
            if (kk <= 3*N+2)   return 3'd5;
            return 3'd6;
        endfunction

        always @(negedge clk) begin
            logic [2:0] es;
            logic       ev;
            int         bitIdx;
            es     = phaseOf(k);
            ev     = (es == 3'd5);
            bitIdx = ev ? (N-1-(k-(2*N+3))) : 0;
            check(gi, "state",    {29'd0, stateObs[gi]},   {29'd0, es});
            check(gi, "des_rst_n", {31'd0, desRstNObs[gi]}, {31'd0, es != 3'd1});
            check(gi, "key_en",   {31'd0, desBus.oKey_en},  {31'd0, es == 3'd2});
            check(gi, "data_en",  {31'd0, desBus.oData_en}, {31'd0, es == 3'd3});
            check(gi, "loading",  {31'd0, desBus.oLoading}, {31'd0, es == 3'd2 || es == 3'd3});
            check(gi, "valid",    {31'd0, valid[gi]},       {31'd0, ev});
            check(gi, "serial",   {31'd0, serial[gi]},      {31'd0, ev && cipher[bitIdx]});
            check(gi, "busy",     {31'd0, busy[gi]},        {31'd0, es != 3'd0});
            check(gi, "done",     {31'd0, done[gi]},        {31'd0, es == 3'd6});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic runJob(input int lane, input logic [31:0] key, input logic [31:0] data,
                          input logic [31:0] expCipher, input int expCycles,
                          input bit midPulse, input bit abortAtStart, input string name);
        logic [31:0] cap;
        int          cyc;
        int          busyCnt;
        bit          seen;
        keyWord[lane]  = key;
        dataWord[lane] = data;
        start[lane]    = 1'b1;
        abort[lane]    = abortAtStart;
        tick(1);
        start[lane] = 1'b0;
        abort[lane] = 1'b0;
        check(lane, {name, ":clear_state"}, {29'd0, stateObs[lane]}, 32'd1);
        check(lane, {name, ":clear_pulse"}, {31'd0, desRstNObs[lane]}, 32'd0);
        cap = '0; cyc = 1; busyCnt = 0; seen = 1'b0;
        while (cyc <= expCycles + 8) begin
            if (busy[lane])  busyCnt++;
            if (valid[lane]) cap = {cap[30:0], serial[lane]};
            if (done[lane]) begin
                seen = 1'b1;
                break;
            end
            start[lane] = midPulse && (cyc == 5);
            tick(1);
            cyc++;
        end
        start[lane] = 1'b0;
        check(lane, {name, ":done_seen"},   {31'd0, seen}, 32'd1);
        check(lane, {name, ":done_cycle"},  cyc,       expCycles);
        check(lane, {name, ":busy_cycles"}, busyCnt,   expCycles);
        check(lane, {name, ":cipher"},      cap,       expCipher);
        tick(1);
        check(lane, {name, ":idle_after"},  {31'd0, busy[lane]}, 32'd0);
        $display("job %s lane%0d key=%h data=%h cipher=%h done_cycle=%0d", name, lane, key, data, cap, cyc);
    endtask

    initial begin
        int hits;
        int firstDone;
        int secondDone;
        rstN = 2'b00; start = 2'b00; abort = 2'b00;
        keyWord[0] = '0; keyWord[1] = '0; dataWord[0] = '0; dataWord[1] = '0;
        tick(3);
        check(0, "reset:state",     {29'd0, stateObs[0]},   32'd0);
        check(0, "reset:des_rst_n", {31'd0, desRstNObs[0]}, 32'd1);
        check(0, "reset:busy",      {31'd0, busy[0]},       32'd0);
        check(0, "reset:valid",     {31'd0, valid[0]},      32'd0);
        check(1, "reset:state",     {29'd0, stateObs[1]},   32'd0);
        rstN = 2'b11;
        tick(2);

        runJob(0, 32'hA5, 32'h3C, 32'h99, 27, 1'b0, 1'b0, "basic");
        runJob(0, 32'hFF, 32'h0F, 32'hF0, 27, 1'b0, 1'b0, "b2b_1");
        runJob(0, 32'h00, 32'hAA, 32'hAA, 27, 1'b0, 1'b0, "b2b_2");

        // Abort in the 4th LOAD_DATA cycle (cycle 13 of the job).
        keyWord[0] = 32'hA5; dataWord[0] = 32'h3C;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(12);
        check(0, "abort:in_load_data", {29'd0, stateObs[0]}, 32'd3);
        abort[0] = 1'b1; tick(1); abort[0] = 1'b0;
        check(0, "abort:idle", {29'd0, stateObs[0]}, 32'd0);
        hits = 0;
        repeat (40) begin
            if (done[0]) hits++;
            tick(1);
        end
        check(0, "abort:no_done", hits, 32'd0);
        $display("job abort lane0 aborted in LOAD_DATA, done pulses=%0d", hits);
        runJob(0, 32'h01, 32'h01, 32'h00, 27, 1'b0, 1'b0, "after_abort");

        runJob(0, 32'h12, 32'h34, 32'h26, 27, 1'b0, 1'b1, "start_with_abort");
        runJob(0, 32'hC3, 32'h81, 32'h42, 27, 1'b1, 1'b0, "mid_start_pulse");

        // Asynchronous reset in the middle of SHIFT.
        keyWord[0] = 32'hA5; dataWord[0] = 32'h3C;
        start[0] = 1'b1; tick(1); start[0] = 1'b0;
        tick(20);
        check(0, "rst_mid:in_shift", {29'd0, stateObs[0]}, 32'd5);
        #1 rstN[0] = 1'b0;
        #1;
        check(0, "rst_mid:state",     {29'd0, stateObs[0]},   32'd0);
        check(0, "rst_mid:valid",     {31'd0, valid[0]},      32'd0);
        check(0, "rst_mid:busy",      {31'd0, busy[0]},       32'd0);
        check(0, "rst_mid:des_rst_n", {31'd0, desRstNObs[0]}, 32'd1);
        tick(2);
        rstN[0] = 1'b1;
        hits = 0;
        repeat (30) begin
            tick(1);
            if (valid[0]) hits++;
        end
        check(0, "rst_mid:no_valid", hits, 32'd0);
        $display("job reset_mid_shift lane0 valid cycles after reset=%0d", hits);

        // iStart held high: two jobs, 28 cycles apart (27 busy + 1 idle).
        keyWord[0] = 32'hFF; dataWord[0] = 32'h0F;
        start[0] = 1'b1;
        hits = 0; firstDone = 0; secondDone = 0;
        for (int j = 1; j <= 56; j++) begin
            tick(1);
            if (done[0]) begin
                hits++;
                if (hits == 1) firstDone = j;
                if (hits == 2) secondDone = j;
            end
        end
        start[0] = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (!busy[0]) break;
            tick(1);
        end
        check(0, "held:done_count", hits, 32'd2);
        check(0, "held:period", secondDone - firstDone, 32'd28);
        check(0, "held:idle", {31'd0, busy[0]}, 32'd0);
        $display("job held_start lane0 dones=%0d at %0d and %0d", hits, firstDone, secondDone);

        runJob(1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h21524110, 99, 1'b0, 1'b0, "wide");

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
